// File: rtl/dot_operand_loader.sv
// dot_operand_loader
//
// Upstream stage of the matrix-multiply reduction tree. Takes one (A, B)
// element pair per cycle over a valid/ready stream. It multiplies each pair
// into the next slot of an N-slot product buffer. Once the buffer is complete,
// it presents the whole buffer as one packed vector to the tree-sum stage.
// Slots that were never written stay zero, so the downstream sum is the exact
// dot product of a short vector.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   in_a, in_b   operand pair (BITS each)
//   in_valid     operand pair / in_last are valid
//   in_last      final pair of the current vector
//   in_ready     loader accepts a pair this cycle (LOAD state, not in reset)
//   out_products packed product buffer, slot k at [k*BITS +: BITS]
//   out_len      number of slots loaded in the presented vector
//   out_valid    out_products / out_len are valid (FULL state)
//   out_ready    downstream consumes the presented vector

module dot_operand_loader #(
    parameter int N    = 32,
    parameter int BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BITS-1:0]            in_a,
    input  logic [BITS-1:0]            in_b,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [N*BITS-1:0]          out_products,
    output logic [$clog2(N+1)-1:0]     out_len,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int IDXW = $clog2(N);
    localparam int LENW = $clog2(N+1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Lower BITS of the product. Two's-complement wrap makes the result
    // identical for signed and unsigned interpretations of the operands.
    function automatic logic [BITS-1:0] wrap_product(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic signed [BITS-1:0] p;
        p = a * b;
        return p;
    endfunction

    logic [0:0]        state_p1;
    logic [IDXW-1:0]   idx_p1;
    logic [N*BITS-1:0] products_p1;
    logic [LENW-1:0]   len_p1;
    logic              vld_p1;

    logic              accept_p0;
    logic              complete_p0;
    logic              consume_p0;
    logic [BITS-1:0]   prod_p0;

    // ---- stage p0: handshake decode and multiply ----
    assign in_ready    = (state_p1 == ST_LOAD) && !rst;
    assign accept_p0   = in_valid && in_ready;
    // The vector ends on in_last or when the buffer fills, whichever is first.
    assign complete_p0 = accept_p0 && ((idx_p1 == IDXW'(N-1)) || in_last);
    assign consume_p0  = (state_p1 == ST_FULL) && vld_p1 && out_ready;
    assign prod_p0     = wrap_product(in_a, in_b);

    // ---- stage p1: product buffer and control registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1    <= ST_LOAD;
            idx_p1      <= '0;
            products_p1 <= '0;
            len_p1      <= '0;
            vld_p1      <= 1'b0;
        end else begin
            case (state_p1)
                ST_LOAD: begin
                    if (accept_p0) begin
                        products_p1[int'(idx_p1)*BITS +: BITS] <= prod_p0;
                        if (complete_p0) begin
                            state_p1 <= ST_FULL;
                            len_p1   <= LENW'(idx_p1) + LENW'(1);
                            vld_p1   <= 1'b1;
                            // idx is cleared here rather than on consume so it
                            // never has to represent N itself.
                            idx_p1   <= '0;
                        end else begin
                            idx_p1   <= idx_p1 + IDXW'(1);
                        end
                    end
                end
                ST_FULL: begin
                    // Clearing the buffer on consume is what keeps padding
                    // slots of the next vector at zero.
                    if (consume_p0) begin
                        state_p1    <= ST_LOAD;
                        idx_p1      <= '0;
                        products_p1 <= '0;
                        len_p1      <= '0;
                        vld_p1      <= 1'b0;
                    end
                end
                default: begin
                    state_p1 <= ST_LOAD;
                    idx_p1   <= '0;
                    vld_p1   <= 1'b0;
                end
            endcase
        end
    end

    assign out_products = products_p1;
    assign out_len      = len_p1;
    assign out_valid    = vld_p1;

endmodule
